// File: rtl/direction_scheduler_pkg.sv
// Shared encodings for the direction scheduler: move directions, PS/2 scancodes,
// parser states and small helpers on the 4-bit request vector {up, down, left, right}.
package direction_scheduler_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        PS_IDLE    = 2'd0,
        PS_EXT     = 2'd1,
        PS_BRK     = 2'd2,
        PS_EXT_BRK = 2'd3
    } parse_state_t;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    // One-hot request bit for an extended arrow scancode, zero for anything else.
    function automatic logic [3:0] key_mask(input logic [7:0] code);
        case (code)
            SC_UP:    key_mask = 4'b1000;
            SC_DOWN:  key_mask = 4'b0100;
            SC_LEFT:  key_mask = 4'b0010;
            SC_RIGHT: key_mask = 4'b0001;
            default:  key_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] cancel_opposing(input logic [3:0] req);
        logic [3:0] res;
        res = req;
        if (req[3] && req[2]) res[3:2] = 2'b00;
        if (req[1] && req[0]) res[1:0] = 2'b00;
        return res;
    endfunction

    function automatic dir_t select_dir(input logic [3:0] req);
        if (req[3])      return DIR_UP;
        else if (req[2]) return DIR_DOWN;
        else if (req[1]) return DIR_LEFT;
        else             return DIR_RIGHT;
    endfunction

endpackage

// File: rtl/direction_scheduler_switch_debouncer.sv
// One switch bit: two-flop synchroniser followed by a stability counter; the
// debounced level toggles only after the synced level has differed long enough.
module direction_scheduler_switch_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 22
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            level_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            if (sync2_reg != level_reg) begin
                if (cnt_reg == CNT_LAST) begin
                    level_reg <= ~level_reg;
                    cnt_reg   <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign level = level_reg;

endmodule

// File: rtl/direction_scheduler.sv
// Turns arrow-key scancodes and debounced push-switches into one move command at a
// time: immediately on first press, then at a fixed repeat rate while held.
module direction_scheduler
    import direction_scheduler_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 2500000,
    parameter int CNT_W           = 22
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_key_pressed,
    input  logic [7:0] ps2_key_data,
    input  logic [3:0] sw_n,
    input  logic       move_ack,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic       move_src,
    output logic [3:0] held
);

    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic [3:0] sw_level;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sw
            direction_scheduler_switch_debouncer #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_debouncer (
                .clock (clock),
                .reset (reset),
                .raw   (~sw_n[gi]),
                .level (sw_level[gi])
            );
        end
    endgenerate

    parse_state_t state_reg, state_next;
    logic [3:0]   kbd_reg, kbd_next;

    always_comb begin
        state_next = state_reg;
        kbd_next   = kbd_reg;
        if (ps2_key_pressed) begin
            state_next = PS_IDLE;
            case (state_reg)
                PS_IDLE: begin
                    if (ps2_key_data == SC_EXT)      state_next = PS_EXT;
                    else if (ps2_key_data == SC_BRK) state_next = PS_BRK;
                end
                PS_EXT: begin
                    if (ps2_key_data == SC_BRK) state_next = PS_EXT_BRK;
                    else                        kbd_next   = kbd_reg | key_mask(ps2_key_data);
                end
                PS_EXT_BRK: kbd_next = kbd_reg & ~key_mask(ps2_key_data);
                default:    state_next = PS_IDLE;
            endcase
        end
    end

    logic       kbd_active;
    logic [3:0] req;
    logic [3:0] held_next;

    // Any held arrow key overrides the switches, even if the keys cancel each other.
    assign kbd_active = |kbd_reg;
    assign req        = kbd_active ? kbd_reg : sw_level;
    assign held_next  = cancel_opposing(req);

    logic [3:0]       held_reg;
    logic [CNT_W-1:0] timer_reg, timer_next;
    logic             issue;

    // The timer sits at zero whenever nothing is held, so a fresh press fires at once.
    always_comb begin
        timer_next = '0;
        issue      = 1'b0;
        if (held_next != 4'b0000) begin
            if (timer_reg == '0) begin
                issue      = 1'b1;
                timer_next = REPEAT_LAST;
            end else begin
                timer_next = timer_reg - 1'b1;
            end
        end
    end

    logic valid_reg;
    dir_t dir_reg;
    logic src_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= PS_IDLE;
            kbd_reg   <= 4'b0000;
            held_reg  <= 4'b0000;
            timer_reg <= '0;
            valid_reg <= 1'b0;
            dir_reg   <= DIR_UP;
            src_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            kbd_reg   <= kbd_next;
            held_reg  <= held_next;
            timer_reg <= timer_next;
            if (valid_reg) begin
                if (move_ack) valid_reg <= 1'b0;
            end else if (issue) begin
                valid_reg <= 1'b1;
                dir_reg   <= select_dir(held_next);
                src_reg   <= kbd_active;
            end
        end
    end

    assign move_valid = valid_reg;
    assign move_dir   = dir_reg;
    assign move_src   = src_reg;
    assign held       = held_reg;

endmodule

// File: tb/tb_direction_scheduler.sv
// Scoreboard bench for direction_scheduler: a behavioural model predicts every move,
// a monitor compares the DUT each cycle and pops expected moves on each valid rise.
module tb_direction_scheduler;

    localparam int DEB = 4;
    localparam int REP = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_key_pressed = 1'b0;
    logic [7:0] ps2_key_data = 8'h00;
    logic [3:0] sw_n = 4'hF;
    logic       move_ack = 1'b0;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       move_src;
    logic [3:0] held;

    always #5 clock = ~clock;

    direction_scheduler #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_CYCLES   (REP),
        .CNT_W           (22)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .ps2_key_pressed (ps2_key_pressed),
        .ps2_key_data    (ps2_key_data),
        .sw_n            (sw_n),
        .move_ack        (move_ack),
        .move_valid      (move_valid),
        .move_dir        (move_dir),
        .move_src        (move_src),
        .held            (held)
    );

    int checks = 0;
    int passed = 0;
    int rises  = 0;

    typedef struct {
        bit [1:0] dir;
        bit       src;
    } move_t;
    move_t exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model (state after the coming clock edge) ----------------
    bit       m_ext, m_brk;        // prefix bytes seen since the last complete code
    bit [3:0] m_keys;              // arrow keys currently down
    bit [3:0] m_raw1, m_raw2;      // pressed levels sampled one and two edges ago
    bit [3:0] m_deb;
    int       m_run[4];            // consecutive cycles synced level disagreed with m_deb
    bit [3:0] m_held;
    int       m_age;               // edges since the last scheduled move
    bit       m_valid;
    bit [1:0] m_dir;
    bit       m_src;

    function automatic int arrow_bit(input bit [7:0] b);
        case (b)
            8'h75:   return 3;
            8'h72:   return 2;
            8'h6B:   return 1;
            8'h74:   return 0;
            default: return -1;
        endcase
    endfunction

    task automatic model_step();
        bit [3:0] h;
        bit       fire;
        int       k;
        if (reset) begin
            m_ext = 0; m_brk = 0; m_keys = 0; m_raw1 = 0; m_raw2 = 0; m_deb = 0;
            for (int b = 0; b < 4; b++) m_run[b] = 0;
            m_held = 0; m_age = 0; m_valid = 0; m_dir = 0; m_src = 0;
            return;
        end
        h = (m_keys != 0) ? m_keys : m_deb;
        if (h[3] && h[2]) h[3:2] = 2'b00;
        if (h[1] && h[0]) h[1:0] = 2'b00;
        fire = 0;
        if (h == 0) begin
            m_age = 0;
        end else if (m_held == 0) begin
            fire = 1; m_age = 0;
        end else begin
            m_age++;
            if (m_age == REP) begin fire = 1; m_age = 0; end
        end
        if (m_valid) begin
            if (move_ack) m_valid = 0;
        end else if (fire) begin
            m_valid = 1;
            m_dir   = h[3] ? 2'd0 : h[2] ? 2'd1 : h[1] ? 2'd2 : 2'd3;
            m_src   = (m_keys != 0);
            exp_q.push_back('{m_dir, m_src});
        end
        m_held = h;
        for (int b = 0; b < 4; b++) begin
            if (m_raw2[b] != m_deb[b]) begin
                m_run[b]++;
                if (m_run[b] == DEB) begin m_deb[b] = ~m_deb[b]; m_run[b] = 0; end
            end else begin
                m_run[b] = 0;
            end
        end
        m_raw2 = m_raw1;
        m_raw1 = ~sw_n;
        if (ps2_key_pressed) begin
            if (ps2_key_data == 8'hE0 && !m_ext && !m_brk) begin
                m_ext = 1;
            end else if (ps2_key_data == 8'hF0 && !m_brk) begin
                m_brk = 1;
            end else begin
                k = arrow_bit(ps2_key_data);
                if (m_ext && k >= 0) m_keys[k] = !m_brk;
                m_ext = 0; m_brk = 0;
            end
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        bit    prev_valid;
        move_t cur;
        prev_valid = 0;
        forever begin
            @(posedge clock);
            #1;
            chk("held", int'(held), int'(m_held));
            chk("move_valid", int'(move_valid), int'(m_valid));
            chk("move_dir", int'(move_dir), int'(m_dir));
            chk("move_src", int'(move_src), int'(m_src));
            if (move_valid && !prev_valid) begin
                rises++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_move", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("sb_dir", int'(move_dir), int'(cur.dir));
                    chk("sb_src", int'(move_src), int'(cur.src));
                end
            end
            prev_valid = move_valid;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        model_step();
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b);
        ps2_key_pressed = 1'b1;
        ps2_key_data    = b;
        tick();
        ps2_key_pressed = 1'b0;
        ps2_key_data    = 8'h00;
    endtask

    task automatic press(input logic [7:0] b);
        send(8'hE0); send(b);
    endtask

    task automatic release_key(input logic [7:0] b);
        send(8'hE0); send(8'hF0); send(b);
    endtask

    initial begin
        logic [7:0] codes [7];
        int         r0;
        codes = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h00};

        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(2);

        // keyboard left with continuous ack, then release
        move_ack = 1'b1;
        press(8'h6B);
        idle(30);
        release_key(8'h6B);
        r0 = rises;
        idle(20);
        chk("no_moves_after_release", rises - r0, 0);

        // short switch glitch, then a real hold
        sw_n = 4'b0111; idle(3);
        sw_n = 4'b1111;
        r0 = rises;
        idle(10);
        chk("glitch_no_move", rises - r0, 0);
        sw_n = 4'b0111;
        idle(12);

        // keyboard right overrides the held up switch, release returns to switch
        press(8'h74);
        idle(12);
        release_key(8'h74);
        idle(12);
        sw_n = 4'b1111;
        idle(10);

        // cancellation and priority
        press(8'h75); press(8'h72); press(8'h6B);
        idle(12);
        release_key(8'h6B);
        r0 = rises;
        idle(12);
        chk("cancel_no_move", rises - r0, 0);
        release_key(8'h75); release_key(8'h72);
        idle(5);

        // handshake stall then ack
        move_ack = 1'b0;
        press(8'h74);
        idle(20);
        move_ack = 1'b1; tick();
        move_ack = 1'b0;
        idle(12);
        move_ack = 1'b1;
        release_key(8'h74);
        idle(5);

        // reset while a move is pending and the parser waits for a break code
        move_ack = 1'b0;
        press(8'h6B);
        idle(3);
        send(8'hE0); send(8'hF0);
        reset = 1'b1; tick();
        reset = 1'b0;
        send(8'h6B);
        idle(10);
        chk("post_reset_held", int'(held), 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int sel;
            if ($urandom_range(0, 3) == 0) begin
                ps2_key_pressed = 1'b1;
                sel = $urandom_range(0, 6);
                ps2_key_data = (sel == 6) ? 8'($urandom) : codes[sel];
            end else begin
                ps2_key_pressed = 1'b0;
            end
            if ($urandom_range(0, 11) == 0) sw_n = 4'($urandom);
            move_ack = ($urandom_range(0, 2) != 0);
            reset    = ($urandom_range(0, 499) == 0);
            tick();
        end
        ps2_key_pressed = 1'b0;
        reset = 1'b0;
        move_ack = 1'b1;
        idle(5);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
